rca32_seq_adder: RTL and testbench
==================================

Name: rca32_seq_adder

Overview:
Multi-precision add/subtract sequencer built around one shared RCA32 32-bit ripple-carry adder. Accepts WORDS×32-bit operands through a valid/ready handshake. Feeds RCA32 one 32-bit limb per clock, least-significant limb first, registering the carry between limbs. Presents the full-width result with carry and signed overflow through a second valid/ready handshake. Trades latency for area in wide-arithmetic paths.

Parameters:
WORDS, 4, number of 32-bit limbs; operand width = 32*WORDS; legal range 2..16.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start_valid  input  1  operands and op are valid.
start_ready  output  1  block can accept a new operation.
op_sub  input  1  0 = a+b+cin; 1 = a-b (two's complement).
a  input  32*WORDS  operand A.
b  input  32*WORDS  operand B.
cin  input  1  carry-in; ignored when op_sub=1.
done_valid  output  1  result is valid.
done_ready  input  1  consumer accepts the result.
sum  output  32*WORDS  result.
cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset, sampled at a clk edge, forces:
  - state = IDLE, start_ready=1, done_valid=0, sum=0, cout=0, ovf=0, limb index=0, carry reg=0.
  - Reset wins over all other inputs, including reset asserted mid-RUN or mid-DONE; any in-flight operation is discarded.
- States IDLE, RUN, DONE; start_ready = (state==IDLE).
- IDLE:
  - Acceptance = start_valid && start_ready at a clk edge.
  - On acceptance: latch a, b_eff (= op_sub ? ~b : b), carry reg (= op_sub ? 1 : cin); idx=0; sum=0; go to RUN.
- RUN:
  - RCA32 is driven combinationally with a_lat[idx], b_eff[idx] and carry reg.
  - Each edge: sum limb idx <= RCA32 s; carry reg <= RCA32 cout; idx <= idx+1.
  - At idx==WORDS-1:
    - cout <= RCA32 cout.
    - ovf <= (a_msb == b_eff_msb) && (s[31] != a_msb), using the top-limb operands.
    - Go to DONE.
  - start_valid is ignored in RUN and DONE; no queuing.
- Latency: done_valid rises exactly WORDS cycles after the accepting edge (WORDS=4: accept at edge 0, done_valid high after edge 4).
- DONE:
  - done_valid=1.
  - sum, cout and ovf are held stable until done_ready is sampled high; then go to IDLE with done_valid=0 at the next edge.
  - Earliest next accept is the edge after that, so throughput is 1 op per WORDS+2 cycles.
  - sum, cout and ovf keep their values in IDLE until the next accept clears sum.
- done_ready while done_valid=0 has no effect.
- Arithmetic: sum = (a + b_eff + carry_in) mod 2^(32*WORDS). The carry is chained between limbs exactly as a 32*WORDS-bit ripple adder would propagate it.
- Limb index width: clog2(WORDS). Index never wraps past WORDS-1.

Decomposition:
- Shared package rca_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - LIMB_W = 32 constant
  - clog2 helper function
- Sub-module: the existing RCA32, instantiated once with port order (s, cout, a, b, cin).
- No other sub-modules; the limb mux and result demux stay in this block.

Test Plan:
1. WORDS=4, a=0, b=0, cin=0, op_sub=0 -> sum=0, cout=0, ovf=0; done_valid high exactly 4 cycles after accept; start_ready=0 throughout.
2. a=2^128-1, b=1, cin=0 -> sum=0, cout=1, ovf=0; the carry ripples across all 4 limbs.
3. a=32'hFFFF_FFFF, b=0, cin=1 -> sum=128'h1_0000_0000, cout=0, which checks the inter-limb carry register.
4. op_sub=1, a=5, b=6, with cin=0 and cin=1 -> sum=2^128-1, cout=0, ovf=0 in both cases (cin ignored); a=6, b=5 -> sum=1, cout=1.
5. a=0x7FFF…F (2^127-1), b=1 -> sum=0x8000…0, ovf=1, cout=0. Follow with op_sub=1, a=0x8000…0, b=1 -> sum=0x7FFF…F, ovf=1.
6. Backpressure and reset:
   - Hold done_ready=0 for 3 cycles in DONE -> sum, cout and ovf stable, done_valid held, and start_valid pulses are ignored.
   - Assert reset for 1 cycle at idx=2 of RUN -> next cycle IDLE, start_ready=1, all outputs 0; a fresh op then completes correctly.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the limb-serial multi-precision adder.
package rca_seq_pkg;

    localparam int LIMB_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rca32_seq_adder_rca32.sv
// 32-bit ripple-carry adder shared by every limb of the sequencer.
module rca32
    import rca_seq_pkg::*;
(
    output logic [LIMB_W-1:0] s,
    output logic              cout,
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin
);

    // One extra bit on the left collects the carry out of bit 31.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};

endmodule

// File: rtl/rca32_seq_adder.sv
// Multi-precision add/subtract: one 32-bit limb per clock through a shared RCA32,
// least-significant limb first, with the inter-limb carry held in a register.
module rca32_seq_adder
    import rca_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    op_sub,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    input  logic                    cin,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);

    localparam int W     = LIMB_W * WORDS;
    localparam int IDX_W = clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [LIMB_W-1:0] rca_a, rca_b, rca_s;
    logic              rca_cout;

    // Limb mux: b_q already holds the inverted operand for subtraction.
    assign rca_a = a_q[int'(idx_q)*LIMB_W +: LIMB_W];
    assign rca_b = b_q[int'(idx_q)*LIMB_W +: LIMB_W];

    rca32 u_rca32 (
        .s    (rca_s),
        .cout (rca_cout),
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*LIMB_W +: LIMB_W] = rca_s;
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    // Top limb: its operand sign bits decide signed overflow.
                    cout_d  = rca_cout;
                    ovf_d   = (rca_a[LIMB_W-1] == rca_b[LIMB_W-1]) &&
                              (rca_s[LIMB_W-1] != rca_a[LIMB_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_rca32_seq_adder.sv
// Directed bench for rca32_seq_adder (WORDS=4) with hand-computed expected results.
module tb_rca32_seq_adder;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_errors;

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    rca32_seq_adder #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic start_op(input logic sub, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic c);
        op_sub      = sub;
        a           = av;
        b           = bv;
        cin         = c;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
    endtask

    // Counts edges after the accepting edge until done_valid; bounded.
    task automatic wait_done(input string tag);
        int  cycles;
        logic busy_ok;
        cycles  = 0;
        busy_ok = 1'b1;
        while (!done_valid && cycles < 20) begin
            if (start_ready) busy_ok = 1'b0;
            step();
            cycles++;
        end
        check({tag, "_latency"}, (W+1)'(cycles), (W+1)'(WORDS));
        check({tag, "_busy"}, (W+1)'(busy_ok), (W+1)'(1));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"},  {1'b0, sum}, {1'b0, es});
        check({tag, "_cout"}, (W+1)'(cout), (W+1)'(ec));
        check({tag, "_ovf"},  (W+1)'(ovf),  (W+1)'(eo));
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check({tag, "_dv_low"}, (W+1)'(done_valid), (W+1)'(0));
        check({tag, "_ready"},  (W+1)'(start_ready), (W+1)'(1));
    endtask

    task automatic run_op(input string tag, input logic sub, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic c, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        start_op(sub, av, bv, c);
        wait_done(tag);
        check_result(tag, es, ec, eo);
        release_done(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        start_valid = 1'b0;
        op_sub      = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        done_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_start_ready", (W+1)'(start_ready), (W+1)'(1));
        check("rst_done_valid",  (W+1)'(done_valid),  (W+1)'(0));
        check_result("rst", '0, 1'b0, 1'b0);

        run_op("zero", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        run_op("ripple_all", 1'b0, ALL_ONES, 128'd1, 1'b0, '0, 1'b1, 1'b0);
        run_op("limb_carry", 1'b0, 128'hFFFF_FFFF, '0, 1'b1,
               128'h1_0000_0000, 1'b0, 1'b0);
        run_op("mid_carry", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000,
               128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0,
               128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
        run_op("sub_5_6_c0", 1'b1, 128'd5, 128'd6, 1'b0, ALL_ONES, 1'b0, 1'b0);
        run_op("sub_5_6_c1", 1'b1, 128'd5, 128'd6, 1'b1, ALL_ONES, 1'b0, 1'b0);
        run_op("sub_6_5", 1'b1, 128'd6, 128'd5, 1'b0, 128'd1, 1'b1, 1'b0);
        run_op("ovf_add", 1'b0, MAX_POS, 128'd1, 1'b0, MIN_NEG, 1'b0, 1'b1);
        run_op("ovf_sub", 1'b1, MIN_NEG, 128'd1, 1'b0, MAX_POS, 1'b1, 1'b1);
        run_op("neg_neg", 1'b0, MIN_NEG, MIN_NEG, 1'b0, '0, 1'b1, 1'b1);

        // Backpressure: results hold while done_ready is low; new starts ignored.
        start_op(1'b0, MAX_POS, 128'd1, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 3; i++) begin
            start_valid = i[0];
            a           = ALL_ONES;
            b           = ALL_ONES;
            step();
            check("bp_hold_dv", (W+1)'(done_valid), (W+1)'(1));
            check("bp_hold_sr", (W+1)'(start_ready), (W+1)'(0));
            check_result("bp_hold", MIN_NEG, 1'b0, 1'b1);
        end
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        release_done("bp");
        check_result("bp_idle_keep", MIN_NEG, 1'b0, 1'b1);

        // Reset in the middle of RUN, at idx=2.
        start_op(1'b0, 128'h1111_1111_2222_2222_3333_3333_4444_4444,
                 128'h0000_0001_0000_0001_0000_0001_0000_0001, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_ready", (W+1)'(start_ready), (W+1)'(1));
        check("rst_mid_dv",    (W+1)'(done_valid),  (W+1)'(0));
        check_result("rst_mid", '0, 1'b0, 1'b0);

        // Fresh op after reset, with done_ready held high from the start.
        done_ready = 1'b1;
        start_op(1'b0, 128'h1111_1111_2222_2222_3333_3333_4444_4444,
                 128'h0000_0001_0000_0001_0000_0001_0000_0001, 1'b0);
        wait_done("post_rst");
        check_result("post_rst", 128'h1111_1112_2222_2223_3333_3334_4444_4445, 1'b0, 1'b0);
        step();
        done_ready = 1'b0;
        check("post_rst_dv_low", (W+1)'(done_valid), (W+1)'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
